// File: rtl/add_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : add_pipe_arbiter
//  Purpose  : Round-robin arbiter sharing one external LAT-stage pipelined
//             adder between N requesters. Issuing-requester tags travel down
//             a valid/index shift register matched to the adder latency.
//             Each result is then registered and returned with a one-hot
//             response strobe.
//  Option   : ADD_PIPE_ARB_PERF_EN enables saturating 16-bit per-requester
//             issue counters on perf_cnt. When it is undefined, perf_cnt is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module add_pipe_arbiter #(
  parameter int N   = 4,
  parameter int LAT = 4,
  parameter int W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  input  logic [N-1:0]     req_cin,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic             add_cin,
  input  logic [W-1:0]     add_sum,
  input  logic             add_cout,
  output logic [N-1:0]     resp_valid,
  output logic [W-1:0]     resp_sum,
  output logic             resp_cout,
  output logic [N*16-1:0]  perf_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Round-robin pointer: index of the most recently granted requester
  logic [IW-1:0]  r_ptr;

  // Tag pipeline: valid bits (reset) and requester indices (no reset needed)
  logic [LAT-1:0] r_tv;
  logic [IW-1:0]  r_ti [LAT];

  // Registered response outputs
  logic [N-1:0]   r_resp_valid;
  logic [W-1:0]   r_resp_sum;
  logic           r_resp_cout;

  // Combinational grant signals
  logic [N-1:0]   w_grant;
  logic [IW-1:0]  w_gidx;
  logic [IW-1:0]  w_cand;
  logic           w_found;
  logic [N-1:0]   w_resp_oh;

  // Grant search: first valid requester starting at ptr+1, wrapping modulo N
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_cand  = '0;
    w_found = 1'b0;
    if (!rst && en) begin
      for (int k = 1; k <= N; k++) begin
        w_cand = IW'((int'(r_ptr) + k) % N);
        if (!w_found && req_valid[w_cand]) begin
          w_found         = 1'b1;
          w_grant[w_cand] = 1'b1;
          w_gidx          = w_cand;
        end
      end
    end
  end

  assign req_ready = w_grant;

  // With no grant, w_gidx is 0, so the adder sees requester 0's operands
  assign add_a   = req_a[int'(w_gidx)*W +: W];
  assign add_b   = req_b[int'(w_gidx)*W +: W];
  assign add_cin = req_cin[w_gidx];

  // The granted requester becomes lowest priority for the next search
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IW'(N - 1);
    end else if (w_found) begin
      r_ptr <= w_gidx;
    end
  end

  // Shift the tag valid bits every cycle. Reset discards in-flight ops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tv <= '0;
    end else begin
      for (int s = LAT - 1; s > 0; s--) begin
        r_tv[s] <= r_tv[s-1];
      end
      r_tv[0] <= w_found;
    end
  end

  // Shift the tag indices alongside the valid bits. They are qualified by r_tv
  always_ff @(posedge clk) begin
    for (int s = LAT - 1; s > 0; s--) begin
      r_ti[s] <= r_ti[s-1];
    end
    r_ti[0] <= w_gidx;
  end

  // Decode the last-stage tag into a one-hot response select
  always_comb begin
    w_resp_oh = '0;
    for (int i = 0; i < N; i++) begin
      w_resp_oh[i] = (r_ti[LAT-1] == IW'(i));
    end
  end

  // Capture the adder result as the matching tag leaves the last stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= '0;
      r_resp_sum   <= '0;
      r_resp_cout  <= 1'b0;
    end else begin
      r_resp_valid <= r_tv[LAT-1] ? w_resp_oh : '0;
      if (r_tv[LAT-1]) begin
        r_resp_sum  <= add_sum;
        r_resp_cout <= add_cout;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_sum   = r_resp_sum;
  assign resp_cout  = r_resp_cout;

`ifdef ADD_PIPE_ARB_PERF_EN
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_perf
      logic [15:0] r_cnt;
      // Count issues by this requester, saturating at all-ones
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_grant[gi] && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      assign perf_cnt[gi*16 +: 16] = r_cnt;
    end
  endgenerate
`else
  assign perf_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_pipe_arbiter
//  Purpose  : Self-checking bench for add_pipe_arbiter with a behavioural
//             LAT-stage adder. A scoreboard queues the expected response for
//             each handshake and compares it when the response appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add_pipe_arbiter;
  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int W   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N-1:0]    req_cin = '0;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    add_a, add_b, add_sum;
  logic            add_cin, add_cout;
  logic [N-1:0]    resp_valid;
  logic [W-1:0]    resp_sum;
  logic            resp_cout;
  logic [N*16-1:0] perf_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [N-1:0] oh;
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  add_pipe_arbiter #(.N(N), .LAT(LAT), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_sum(resp_sum), .resp_cout(resp_cout),
    .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural shared adder: LAT register stages, no reset, no valid
  logic [W:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign add_sum  = apipe[LAT-1][W-1:0];
  assign add_cout = apipe[LAT-1][W];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant rules, scoreboard push on handshake, pop on response
  always @(negedge clk) begin
    exp_t e;
    logic [W:0] t;
    checks++;
    if (($countones(req_ready) > 1) || ((rst || !en) && (req_ready != '0)) ||
        ((req_ready & ~req_valid) != '0)) begin
      errors++;
      $display("FAIL grant_rule ready=%b valid=%b rst=%b en=%b", req_ready, req_valid, rst, en);
    end
    if (resp_valid != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp cyc=%0d resp_valid=%b sum=%h", cyc, resp_valid, resp_sum);
      end else begin
        e = sb.pop_front();
        if (resp_valid !== e.oh || resp_sum !== e.sum || resp_cout !== e.cout ||
            cyc !== e.cyc + LAT + 1) begin
          errors++;
          $display("FAIL sb_resp cyc=%0d got v=%b s=%h c=%b want v=%b s=%h c=%b at cyc=%0d",
                   cyc, resp_valid, resp_sum, resp_cout, e.oh, e.sum, e.cout, e.cyc + LAT + 1);
        end
      end
    end else if (sb.size() > 0 && cyc >= sb[0].cyc + LAT + 1) begin
      checks++;
      errors++;
      $display("FAIL missing_resp cyc=%0d got v=%b want v=%b", cyc, resp_valid, sb[0].oh);
      void'(sb.pop_front());
    end
    if (rst) begin
      sb.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          t = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]} + {{W{1'b0}}, req_cin[i]};
          e.oh   = N'(1) << i;
          e.sum  = t[W-1:0];
          e.cout = t[W];
          e.cyc  = cyc;
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  task automatic do_reset;
    req_valid = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drain;
    repeat (LAT + 3) tick();
  endtask

  task automatic drive_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    bit got = 0;
    set_op(i, a, b, c);
    req_valid[i] = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
      tick();
      n++;
    end
    req_valid[i] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL drive_timeout req=%0d got=0 want=1", i);
    end
  endtask

  task automatic test_reset;
    en = 1'b1;
    rst = 1'b1;
    req_valid = '1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b want=0", req_ready); end
    checks++;
    if (resp_valid !== '0 || resp_sum !== '0 || resp_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp got v=%b s=%h c=%b want 0/0/0", resp_valid, resp_sum, resp_cout);
    end
    checks++;
    if (perf_cnt !== '0) begin errors++; $display("FAIL reset_perf got=%h want=0", perf_cnt); end
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_op;
    int n = 0;
    bit seen = 0;
    set_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b want=0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid != '0) seen = 1;
    end
    checks++;
    if (!seen || n !== LAT + 1) begin errors++; $display("FAIL single_latency got=%0d want=%0d", n, LAT + 1); end
    checks++;
    if (resp_valid !== 4'b0001 || resp_sum !== 32'd0 || resp_cout !== 1'b1) begin
      errors++;
      $display("FAIL single_value got v=%b s=%h c=%b want 0001/0/1", resp_valid, resp_sum, resp_cout);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== '0 || resp_sum !== 32'd0 || resp_cout !== 1'b1) begin
      errors++;
      $display("FAIL single_hold got v=%b s=%h c=%b want 0000/0/1", resp_valid, resp_sum, resp_cout);
    end
    tick();
    drain();
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_g;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    req_valid = '1;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      exp_g = N'(1) << (k % N);
      checks++;
      if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, exp_g); end
      tick();
    end
    req_valid = '0;
    drain();
  endtask

  task automatic test_back_to_back;
    int n = 0;
    bit seen = 0;
    set_op(2, 32'd1, 32'd2, 1'b0);
    req_valid[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_grant got=%b want=0100", req_ready); end
    tick();
    set_op(2, 32'd10, 32'd20, 1'b1);
    tick();
    set_op(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
    tick();
    req_valid[2] = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid != '0) seen = 1;
    end
    checks++;
    if (!seen || n !== LAT - 1) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", n, LAT - 1); end
    checks++;
    if (resp_valid !== 4'b0100 || resp_sum !== 32'd3 || resp_cout !== 1'b0) begin
      errors++; $display("FAIL b2b_r0 got v=%b s=%h c=%b want 0100/3/0", resp_valid, resp_sum, resp_cout);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0100 || resp_sum !== 32'd31 || resp_cout !== 1'b0) begin
      errors++; $display("FAIL b2b_r1 got v=%b s=%h c=%b want 0100/31/0", resp_valid, resp_sum, resp_cout);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0100 || resp_sum !== 32'd0 || resp_cout !== 1'b1) begin
      errors++; $display("FAIL b2b_r2 got v=%b s=%h c=%b want 0100/0/1", resp_valid, resp_sum, resp_cout);
    end
    tick();
    drain();
  endtask

  task automatic test_en;
    do_reset();
    en = 1'b0;
    set_op(1, 32'd100, 32'd5, 1'b0);
    set_op(3, 32'd7, 32'd9, 1'b1);
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL en_block got=%b want=0000", req_ready); end
      tick();
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL en_first got=%b want=0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL en_second got=%b want=1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    drain();
  endtask

  task automatic test_reset_midflight;
    int pulses = 0;
    int n = 0;
    bit seen = 0;
    set_op(0, 32'd11, 32'd22, 1'b0);
    req_valid[0] = 1'b1;
    tick();
    set_op(0, 32'd33, 32'd44, 1'b1);
    tick();
    set_op(0, 32'd55, 32'd66, 1'b0);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk); if (resp_valid != '0) pulses++;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); if (resp_valid != '0) pulses++;
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); if (resp_valid != '0) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL rst_flush got=%0d pulses want=0", pulses); end
    set_op(1, 32'd7, 32'd8, 1'b1);
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid != '0) seen = 1;
    end
    checks++;
    if (!seen || n !== LAT + 1) begin errors++; $display("FAIL post_rst_latency got=%0d want=%0d", n, LAT + 1); end
    checks++;
    if (resp_valid !== 4'b0010 || resp_sum !== 32'd16 || resp_cout !== 1'b0) begin
      errors++; $display("FAIL post_rst_value got v=%b s=%h c=%b want 0010/16/0", resp_valid, resp_sum, resp_cout);
    end
    tick();
    drain();
  endtask

  task automatic test_perf;
    logic [N*16-1:0] exp_p;
    do_reset();
    for (int k = 0; k < 5; k++) drive_op(0, W'(k), W'(k * 3), 1'b0);
    for (int k = 0; k < 2; k++) drive_op(3, W'(k + 40), 32'd1, 1'b1);
    drain();
`ifdef ADD_PIPE_ARB_PERF_EN
    exp_p = {16'd2, 16'd0, 16'd0, 16'd5};
`else
    exp_p = '0;
`endif
    checks++;
    if (perf_cnt !== exp_p) begin errors++; $display("FAIL perf_cnt got=%h want=%h", perf_cnt, exp_p); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_back_to_back();
    test_en();
    test_reset_midflight();
    test_perf();
    drain();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
